// File: rtl/outbuf_writer_b1.sv
// outbuf_writer_b1: packs 4-bit per-channel samples MSB-first into 32-bit words for the eight block-1 output SPRAM banks.
// Optional feature macro: OUTBUF_WR_ERR_EN builds the sticky protocol-error detector behind err; otherwise err is tied low.
module outbuf_writer_b1 #(
    parameter int NUM_WORDS   = 226,
    parameter int NUM_SAMPLES = 1808,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              system_rst_n,
    input  logic              start,
    input  logic              clr,
    input  logic              valid_in,
    input  logic [3:0]        din_0,
    input  logic [3:0]        din_1,
    input  logic [3:0]        din_2,
    input  logic [3:0]        din_3,
    input  logic [3:0]        din_4,
    input  logic [3:0]        din_5,
    input  logic [3:0]        din_6,
    input  logic [3:0]        din_7,
    output logic              busy,
    output logic [ADDR_W-1:0] ADDR,
    output logic              WEA,
    output logic              ENA,
    output logic [31:0]       DINA_0,
    output logic [31:0]       DINA_1,
    output logic [31:0]       DINA_2,
    output logic [31:0]       DINA_3,
    output logic [31:0]       DINA_4,
    output logic [31:0]       DINA_5,
    output logic [31:0]       DINA_6,
    output logic [31:0]       DINA_7,
    output logic              frame_done,
    output logic              err
);
    localparam int SC_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [SC_W-1:0] FULL = SC_W'(NUM_SAMPLES);
    localparam logic [SC_W-1:0] LAST = SC_W'(NUM_SAMPLES - 1);

    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 8 * NUM_WORDS) begin : g_bad_cfg
        $error("outbuf_writer_b1: NUM_SAMPLES must be in 1..8*NUM_WORDS");
    end

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;
    state_t state;

    logic [2:0]      nib_cnt;
    logic [SC_W-1:0] samp_cnt;
    logic [3:0]      din  [8];
    logic [27:0]     sreg [8];
    logic [31:0]     dina [8];
    logic            take;
    logic            word_full;

    assign din = '{din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7};
    assign take = (state == FILL) && valid_in && (samp_cnt != FULL);
    assign word_full = take && (nib_cnt == 3'd7);
    assign ENA = WEA;
    assign DINA_0 = dina[0];
    assign DINA_1 = dina[1];
    assign DINA_2 = dina[2];
    assign DINA_3 = dina[3];
    assign DINA_4 = dina[4];
    assign DINA_5 = dina[5];
    assign DINA_6 = dina[6];
    assign DINA_7 = dina[7];

    // frame sequencing: counts samples, issues one write strobe per packed word, ends the frame with frame_done
    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state      <= IDLE;
            nib_cnt    <= '0;
            samp_cnt   <= '0;
            ADDR       <= '0;
            WEA        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            nib_cnt    <= '0;
            samp_cnt   <= '0;
            ADDR       <= '0;
            WEA        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            WEA        <= 1'b0;
            frame_done <= 1'b0;
            if (WEA) ADDR <= ADDR + ADDR_W'(1);
            case (state)
                IDLE: if (start) begin
                    state    <= FILL;
                    busy     <= 1'b1;
                    nib_cnt  <= '0;
                    samp_cnt <= '0;
                end
                FILL: if (take) begin
                    nib_cnt  <= nib_cnt + 3'd1;
                    samp_cnt <= samp_cnt + SC_W'(1);
                    WEA      <= word_full;
                    if (samp_cnt == LAST && !word_full) state <= FLUSH;
                end else if (WEA && samp_cnt == FULL) begin
                    state      <= DONE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    ADDR       <= '0;
                end
                FLUSH: begin
                    WEA     <= 1'b1;
                    nib_cnt <= '0;
                    state   <= FILL;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    // per-channel packing; a completed or flushed word clears the shift register so the next word starts clean
    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            for (int k = 0; k < 8; k++) begin
                sreg[k] <= '0;
                dina[k] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < 8; k++) begin
                sreg[k] <= '0;
                dina[k] <= '0;
            end
        end else if (state == FLUSH) begin
            for (int k = 0; k < 8; k++) begin
                dina[k] <= {sreg[k], 4'h0} << {~nib_cnt, 2'b00};
                sreg[k] <= '0;
            end
        end else if (take) begin
            for (int k = 0; k < 8; k++) begin
                sreg[k] <= word_full ? '0 : {sreg[k][23:0], din[k]};
                if (word_full) dina[k] <= {sreg[k], din[k]};
            end
        end
    end

`ifdef OUTBUF_WR_ERR_EN
    // sticky protocol error: start while busy, or a sample offered outside FILL
    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) err <= 1'b0;
        else if (clr) err <= 1'b0;
        else if ((start && busy) || (valid_in && state != FILL)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_outbuf_writer_b1.sv
// tb_outbuf_writer_b1: directed stimulus against a full-size instance and a 13-sample instance, with a write scoreboard per instance.
module tb_outbuf_writer_b1;
    typedef struct packed {
        logic [7:0]   addr;
        logic [255:0] data;
    } wr_t;

`ifdef OUTBUF_WR_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        system_rst_n, start, clr, valid_in;
    logic [3:0]  din [8];
    logic        a_busy, a_wea, a_ena, a_fd, a_err;
    logic [7:0]  a_addr;
    logic [31:0] a_dina [8];
    logic        b_busy, b_wea, b_ena, b_fd, b_err;
    logic [7:0]  b_addr;
    logic [31:0] b_dina [8];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wcnt = 0;
    int          base;
    wr_t         q0[$];
    wr_t         q1[$];
    logic [31:0] m_acc [2][8];
    int          m_n [2];
    int          m_a [2];
    int          m_s [2];
    bit          m_act [2];
    int          lim [2] = '{1808, 13};
    logic [31:0] d;

    always #5 clk = ~clk;

    outbuf_writer_b1 u_a (
        .clk(clk), .system_rst_n(system_rst_n), .start(start), .clr(clr), .valid_in(valid_in),
        .din_0(din[0]), .din_1(din[1]), .din_2(din[2]), .din_3(din[3]),
        .din_4(din[4]), .din_5(din[5]), .din_6(din[6]), .din_7(din[7]),
        .busy(a_busy), .ADDR(a_addr), .WEA(a_wea), .ENA(a_ena),
        .DINA_0(a_dina[0]), .DINA_1(a_dina[1]), .DINA_2(a_dina[2]), .DINA_3(a_dina[3]),
        .DINA_4(a_dina[4]), .DINA_5(a_dina[5]), .DINA_6(a_dina[6]), .DINA_7(a_dina[7]),
        .frame_done(a_fd), .err(a_err)
    );

    outbuf_writer_b1 #(.NUM_WORDS(2), .NUM_SAMPLES(13), .ADDR_W(8)) u_b (
        .clk(clk), .system_rst_n(system_rst_n), .start(start), .clr(clr), .valid_in(valid_in),
        .din_0(din[0]), .din_1(din[1]), .din_2(din[2]), .din_3(din[3]),
        .din_4(din[4]), .din_5(din[5]), .din_6(din[6]), .din_7(din[7]),
        .busy(b_busy), .ADDR(b_addr), .WEA(b_wea), .ENA(b_ena),
        .DINA_0(b_dina[0]), .DINA_1(b_dina[1]), .DINA_2(b_dina[2]), .DINA_3(b_dina[3]),
        .DINA_4(b_dina[4]), .DINA_5(b_dina[5]), .DINA_6(b_dina[6]), .DINA_7(b_dina[7]),
        .frame_done(b_fd), .err(b_err)
    );

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic emit(input int i);
        wr_t w;
        w.addr = 8'(m_a[i]);
        for (int k = 0; k < 8; k++) w.data[255-32*k -: 32] = m_acc[i][k];
        if (i == 0) q0.push_back(w);
        else q1.push_back(w);
        m_a[i]++;
        m_n[i] = 0;
        for (int k = 0; k < 8; k++) m_acc[i][k] = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_act[i] && valid_in) begin
                for (int k = 0; k < 8; k++) m_acc[i][k] = {m_acc[i][k][27:0], din[k]};
                m_n[i]++;
                m_s[i]++;
                if (m_n[i] == 8) emit(i);
                if (m_s[i] == lim[i]) begin
                    if (m_n[i] != 0) begin
                        for (int k = 0; k < 8; k++) m_acc[i][k] = m_acc[i][k] << (4 * (8 - m_n[i]));
                        emit(i);
                    end
                    m_act[i] = 1'b0;
                end
            end else if (!m_act[i] && start) begin
                m_act[i] = 1'b1;
                m_n[i] = 0;
                m_s[i] = 0;
                m_a[i] = 0;
                for (int k = 0; k < 8; k++) m_acc[i][k] = '0;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_n[i] = 0;
            m_s[i] = 0;
            m_a[i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic step(input logic v, input logic [31:0] dv, input logic s);
        valid_in = v;
        start = s;
        for (int k = 0; k < 8; k++) din[k] = dv[4*k +: 4];
        model_step();
        @(posedge clk);
        #1;
    endtask

    // write scoreboard: every strobe must match the oldest expected word of that instance
    always @(negedge clk) begin
        if (system_rst_n) begin
            check("a_ena_eq_wea", a_ena, a_wea);
            check("b_ena_eq_wea", b_ena, b_wea);
            if (a_wea) begin
                wcnt++;
                check("a_write_expected", q0.size() != 0, 1'b1);
                if (q0.size() != 0)
                    check("a_write", {a_addr, a_dina[0], a_dina[1], a_dina[2], a_dina[3],
                                      a_dina[4], a_dina[5], a_dina[6], a_dina[7]}, q0.pop_front());
            end
            if (b_wea) begin
                check("b_write_expected", q1.size() != 0, 1'b1);
                if (q1.size() != 0)
                    check("b_write", {b_addr, b_dina[0], b_dina[1], b_dina[2], b_dina[3],
                                      b_dina[4], b_dina[5], b_dina[6], b_dina[7]}, q1.pop_front());
            end
        end
    end

    initial begin
        system_rst_n = 1'b0;
        start = 1'b0;
        clr = 1'b0;
        valid_in = 1'b0;
        for (int k = 0; k < 8; k++) din[k] = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_wea", a_wea, 1'b0);
        check("rst_addr", a_addr, 8'd0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_fd, 1'b0);
        check("rst_dina0", a_dina[0], 32'd0);
        check("rst_err", a_err, 1'b0);
        system_rst_n = 1'b1;
        step(0, 0, 0);

        // first word latency, then the rest of a full back-to-back frame
        base = wcnt;
        step(0, 0, 1);
        check("start_busy", a_busy, 1'b1);
        for (int j = 0; j < 1808; j++) begin
            d = $urandom;
            d[3:0] = 4'(j);
            step(1, d, 0);
            if (j == 6) check("first_wea_early", a_wea, 1'b0);
            if (j == 7) begin
                check("first_wea", a_wea, 1'b1);
                check("first_addr", a_addr, 8'd0);
                check("first_dina0", a_dina[0], 32'h01234567);
                check("first_ena", a_ena, 1'b1);
            end
            if (j == 8) check("addr_inc", a_addr, 8'd1);
        end
        check("last_wea", a_wea, 1'b1);
        check("last_addr", a_addr, 8'd225);
        check("last_busy", a_busy, 1'b1);
        step(0, 0, 0);
        check("frame_done", a_fd, 1'b1);
        check("done_busy", a_busy, 1'b0);
        check("done_addr", a_addr, 8'd0);
        check("done_wea", a_wea, 1'b0);
        check("frame_writes", wcnt - base, 226);
        step(0, 0, 0);
        check("done_pulse", a_fd, 1'b0);
        check("err_quiet", a_err, 1'b0);
        repeat (3) step(0, 0, 0);

        // 13-sample instance flushes a partial word; then bubbles and clr on the full-size instance
        step(0, 0, 1);
        for (int j = 0; j < 13; j++) begin
            d = $urandom;
            d[15:12] = 4'hF;
            step(1, d, 0);
        end
        check("flush_wea_early", b_wea, 1'b0);
        step(0, 0, 0);
        check("flush_wea", b_wea, 1'b1);
        check("flush_addr", b_addr, 8'd1);
        check("flush_dina3", b_dina[3], 32'hFFFFF000);
        d = $urandom;
        step(1, d, 0);
        check("flush_done", b_fd, 1'b1);
        check("flush_busy", b_busy, 1'b0);
        check("flush_addr0", b_addr, 8'd0);
        for (int j = 14; j < 20; j++) begin
            step(0, 0, 0);
            d = $urandom;
            step(1, d, 0);
            if (j == 15) begin
                check("bubble_wea", a_wea, 1'b1);
                check("bubble_addr", a_addr, 8'd1);
            end
        end
        clr = 1'b1;
        step(0, 0, 0);
        clr = 1'b0;
        model_clear();
        check("clr_wea", a_wea, 1'b0);
        check("clr_addr", a_addr, 8'd0);
        check("clr_busy", a_busy, 1'b0);
        check("clr_dina0", a_dina[0], 32'd0);
        step(0, 0, 0);

        // restart after clr writes from address 0, then async reset while the strobe is high
        step(0, 0, 1);
        for (int j = 0; j < 8; j++) begin
            d = $urandom;
            step(1, d, 0);
        end
        check("restart_wea", a_wea, 1'b1);
        check("restart_addr", a_addr, 8'd0);
        system_rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        check("arst_wea", a_wea, 1'b0);
        check("arst_addr", a_addr, 8'd0);
        check("arst_dina0", a_dina[0], 32'd0);
        check("arst_b_wea", b_wea, 1'b0);
        check("arst_busy", a_busy, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        system_rst_n = 1'b1;
        step(0, 0, 0);
        check("arst_no_done", a_fd, 1'b0);
        step(0, 0, 0);
        check("arst_no_done2", a_fd, 1'b0);

        // start while busy: flagged only when the error detector is built, frame unaffected
        base = wcnt;
        step(0, 0, 1);
        for (int j = 0; j < 1808; j++) begin
            d = $urandom;
            step(1, d, j == 10);
            if (j == 10) check("err_set", a_err, ERR_EXP);
        end
        check("err_last_addr", a_addr, 8'd225);
        step(0, 0, 0);
        check("err_frame_done", a_fd, 1'b1);
        check("err_held", a_err, ERR_EXP);
        check("err_frame_writes", wcnt - base, 226);
        repeat (3) step(0, 0, 0);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
